inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Fetch-side consumer of the PC register. Samples pc, issues one request at a time on the
//  instruction-memory req/gnt/rvalid bus, and queues returned words with their PC for decode.
//  Drives pcAdvance so the PC steps to pc4 only after a fetch is launched.
//  Discards in-flight responses when the pipeline redirects (branch, jump, exception).
// PARAMETERS
//  DEPTH     2             instruction queue entries; power of 2, >= 2
//  RESET_PC  32'h0000_3000 reset value of imemAddr; matches the PC reset vector
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  pc           in   32  current PC register value
//  redirect     in   1   takeBranch|takeJumpImm|takeJumpReg|takeException; PC loads the target at the same edge
//  pcAdvance    out  1   PC loads pc4 at the next edge (combinational)
//  imemReq      out  1   bus request valid
//  imemAddr     out  32  bus request address; stable while imemReq=1 and imemGnt=0
//  imemGnt      in   1   request accepted this cycle
//  imemRvalid   in   1   response valid (>=1 cycle after gnt)
//  imemRdata    in   32  response word
//  instValid    out  1   queue head valid
//  instr        out  32  queue head instruction word
//  instPc       out  32  queue head PC
//  instAddrErr  out  1   queue head is a misaligned-fetch marker (instr=0)
//  decodeReady  in   1   pop the head when instValid=1
// BEHAVIOUR
//  Reset: state IDLE; imemReq=0; imemAddr=RESET_PC; queue empty; instValid=0; instr=0;
//   instPc=0; instAddrErr=0; pcAdvance=0. Reset mid-transaction drops the outstanding
//   request; the bus side ignores a later rvalid.
//  Outputs are registered, except pcAdvance (combinational, forced 0 while rst=1).
//  At most one outstanding request. cnt is the queue occupancy.
//  States and transitions (evaluated in the order listed):
//   IDLE:  redirect -> IDLE.
//          cnt<DEPTH and pc[1:0]!=0 -> push {pc, 0, err=1}, go to ERR; no bus request.
//          cnt<DEPTH -> imemAddr<=pc, pcAdvance=1, go to REQ.
//   REQ:   imemReq=1. gnt & redirect -> DROP. gnt -> WAIT.
//          redirect without gnt -> hold the request (address stays stable), then DROP after gnt.
//   WAIT:  rvalid & redirect -> discard the word, go to IDLE.
//          redirect -> DROP.
//          rvalid -> push {imemAddr, rdata, 0}. Then, if cnt<=DEPTH-2 (before the push) and
//          pc[1:0]==0, imemAddr<=pc, pcAdvance=1, go to REQ (back-to-back). Otherwise go to IDLE.
//   DROP:  rvalid -> discard, go to IDLE. Further redirects are ignored.
//   ERR:   wait here; redirect -> IDLE (the exception redirect flushes).
//  Redirect in any state flushes the queue at that edge: cnt=0, instValid=0 next cycle.
//   Flush wins over a same-cycle pop or push.
//  Push and pop in the same cycle: cnt is unchanged.
//  Pointers wrap modulo DEPTH. No push is ever attempted when full; the issue rules guarantee a slot.
//  Throughput: 1 instruction per (bus latency + 1) cycles with DEPTH>=2 and decode never stalling.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds output perfFetched[31:0] (pops, wraps at 2^32) and output
//   perfBusStall[31:0] (cycles with imemReq=1 and imemGnt=0). Both reset to 0 and are not
//   cleared by redirect.
//  FETCH_PERF_EN undefined: neither port nor its counter exists; all other behaviour is identical.
// TESTING
//  1. Reset, pc=0x3000, zero-wait bus (gnt same cycle, rvalid next) -> imemAddr 0x3000,0x3004,0x3008
//     in order; instPc matches; instValid one cycle after each rvalid.
//  2. decodeReady=0 with DEPTH=2 -> exactly 2 entries queued; imemReq stays low; pcAdvance=0
//     until the first pop.
//  3. redirect in WAIT (pc=0x3008 -> 0x3100), rvalid 2 cycles later with 0xDEADBEEF -> word
//     discarded; next imemAddr=0x3100; instValid=0 from the redirect+1 cycle.
//  4. redirect and rvalid in the same cycle -> word discarded, state IDLE; imemReq rises 1 cycle later.
//  5. pc=0x3002 in IDLE -> no imemReq; head {instPc=0x3002, instAddrErr=1, instr=0};
//     stays in ERR until redirect.
//  6. gnt held low 5 cycles in REQ, redirect in cycle 2 -> imemAddr stable all 5 cycles; DROP
//     after gnt; with FETCH_PERF_EN, perfBusStall=5.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: one outstanding req/gnt/rvalid fetch at a time, feeding a small
// queue of {pc, word, misaligned} entries. Define FETCH_PERF_EN to add perf counters.
module inst_fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        redirect,
    output logic        pcAdvance,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic        instValid,
    output logic [31:0] instr,
    output logic [31:0] instPc,
    output logic        instAddrErr,
    input  logic        decodeReady,
`ifdef FETCH_PERF_EN
    output logic [31:0] perfFetched,
    output logic [31:0] perfBusStall,
`endif
    output logic [2:0]  dbg_state_o
);

    // Bus handshake: the request is offered while imemReq=1 and completes on the
    // cycle imemGnt=1; imemAddr is held stable until then. Exactly one word returns
    // on imemRvalid at least one cycle after the grant. The decode side pops the
    // queue head on any cycle with instValid=1 and decodeReady=1.

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] B2B_CNT  = CW'(DEPTH - 2);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DROP = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
        logic        err;
    } entry_t;

    state_t          state_q, state_d;
    logic            req_d;
    logic [31:0]     addr_d;
    logic            drop_pend_q, drop_pend_d;
    logic            launch;
    logic            push;
    entry_t          push_entry;
    logic            pop;
    logic            flush;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   wr_q, wr_d;
    entry_t          mem_q [DEPTH];
    entry_t          head_d;
    logic            head_valid_d;

    assign dbg_state_o = state_q;
    assign pcAdvance   = launch && !rst;

    // Next-state decisions; a launch (from IDLE or back-to-back from WAIT) always
    // loads the address from pc and enters REQ.
    always_comb begin
        state_d     = state_q;
        req_d       = imemReq;
        addr_d      = imemAddr;
        drop_pend_d = drop_pend_q;
        launch      = 1'b0;
        push        = 1'b0;
        push_entry  = '0;
        case (state_q)
            S_IDLE: begin
                if (!redirect && (cnt_q < FULL_CNT)) begin
                    if (pc[1:0] != 2'b00) begin
                        push       = 1'b1;
                        push_entry = '{pc: pc, word: 32'h0, err: 1'b1};
                        state_d    = S_ERR;
                    end else begin
                        launch = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (imemGnt) begin
                    req_d       = 1'b0;
                    drop_pend_d = 1'b0;
                    state_d     = (redirect || drop_pend_q) ? S_DROP : S_WAIT;
                end else if (redirect) begin
                    // Cannot withdraw an offered request; remember to drop its response.
                    drop_pend_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imemRvalid && redirect) begin
                    state_d = S_IDLE;
                end else if (redirect) begin
                    state_d = S_DROP;
                end else if (imemRvalid) begin
                    push       = 1'b1;
                    push_entry = '{pc: imemAddr, word: imemRdata, err: 1'b0};
                    if ((cnt_q <= B2B_CNT) && (pc[1:0] == 2'b00)) begin
                        launch = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (imemRvalid) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (redirect) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (launch) begin
            addr_d  = pc;
            req_d   = 1'b1;
            state_d = S_REQ;
        end
    end

    // Queue bookkeeping; the head registers are loaded with the post-update head.
    always_comb begin
        flush = redirect;
        pop   = instValid && decodeReady && !flush;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            if (push) begin
                wr_d = wr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
        head_valid_d = (cnt_d != '0);
        if (push && !flush && (wr_q == rd_d)) begin
            head_d = push_entry;
        end else begin
            head_d = mem_q[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            imemReq      <= 1'b0;
            imemAddr     <= RESET_PC;
            drop_pend_q  <= 1'b0;
            cnt_q        <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            instValid    <= 1'b0;
            instr        <= 32'h0;
            instPc       <= 32'h0;
            instAddrErr  <= 1'b0;
`ifdef FETCH_PERF_EN
            perfFetched  <= 32'h0;
            perfBusStall <= 32'h0;
`endif
        end else begin
            state_q     <= state_d;
            imemReq     <= req_d;
            imemAddr    <= addr_d;
            drop_pend_q <= drop_pend_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            if (push && !flush) begin
                mem_q[wr_q] <= push_entry;
            end
            instValid   <= head_valid_d;
            instr       <= head_valid_d ? head_d.word : 32'h0;
            instPc      <= head_valid_d ? head_d.pc : 32'h0;
            instAddrErr <= head_valid_d ? head_d.err : 1'b0;
`ifdef FETCH_PERF_EN
            if (pop) begin
                perfFetched <= perfFetched + 32'd1;
            end
            if (imemReq && !imemGnt) begin
                perfBusStall <= perfBusStall + 32'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: hand-driven bus, a PC register model, and
// immediate-assertion checks against hand-computed values.
module tb_inst_fetch_unit;

    localparam logic [31:0] ST_IDLE = 32'd0;
    localparam logic [31:0] ST_REQ  = 32'd1;
    localparam logic [31:0] ST_WAIT = 32'd2;
    localparam logic [31:0] ST_DROP = 32'd3;
    localparam logic [31:0] ST_ERR  = 32'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] target;
    logic        redirect;
    logic        pcAdvance;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        instValid;
    logic [31:0] instr;
    logic [31:0] instPc;
    logic        instAddrErr;
    logic        decodeReady;
    logic [2:0]  dbg_state;
`ifdef FETCH_PERF_EN
    logic [31:0] perfFetched;
    logic [31:0] perfBusStall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .redirect    (redirect),
        .pcAdvance   (pcAdvance),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemGnt     (gnt),
        .imemRvalid  (rvalid),
        .imemRdata   (rdata),
        .instValid   (instValid),
        .instr       (instr),
        .instPc      (instPc),
        .instAddrErr (instAddrErr),
        .decodeReady (decodeReady),
`ifdef FETCH_PERF_EN
        .perfFetched (perfFetched),
        .perfBusStall(perfBusStall),
`endif
        .dbg_state_o (dbg_state)
    );

    // PC register of the surrounding pipeline.
    always @(posedge clk) begin
        if (rst) begin
            pc <= 32'h0000_3000;
        end else if (redirect) begin
            pc <= target;
        end else if (pcAdvance) begin
            pc <= pc + 32'd4;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] exp);
        chk32(tag, {29'b0, dbg_state}, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; target = 32'h0; gnt = 1'b0;
        rvalid = 1'b0; rdata = 32'h0; decodeReady = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, pcAdvance forced low while rst=1
        rst = 1'b1; redirect = 1'b0; target = 32'h0; gnt = 1'b0;
        rvalid = 1'b0; rdata = 32'h0; decodeReady = 1'b0;
        tick();
        tick();
        chk_state("rst_state", ST_IDLE);
        chk1("rst_req", imemReq, 1'b0);
        chk32("rst_addr", imemAddr, 32'h0000_3000);
        chk1("rst_valid", instValid, 1'b0);
        chk32("rst_instr", instr, 32'h0);
        chk32("rst_instpc", instPc, 32'h0);
        chk1("rst_err", instAddrErr, 1'b0);
        chk1("rst_pcadv", pcAdvance, 1'b0);

        // Zero-wait bus, decode always ready
        decodeReady = 1'b1; rst = 1'b0; #1;
        chk1("t1_c0_pcadv", pcAdvance, 1'b1);
        tick();
        chk1("t1_c1_req", imemReq, 1'b1);
        chk32("t1_c1_addr", imemAddr, 32'h0000_3000);
        gnt = 1'b1; tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h1111_1111; #1;
        chk_state("t1_c2_state", ST_WAIT);
        chk1("t1_c2_req", imemReq, 1'b0);
        chk1("t1_c2_pcadv", pcAdvance, 1'b1);
        chk1("t1_c2_valid", instValid, 1'b0);
        tick();
        rvalid = 1'b0; #1;
        chk1("t1_c3_valid", instValid, 1'b1);
        chk32("t1_c3_instpc", instPc, 32'h0000_3000);
        chk32("t1_c3_instr", instr, 32'h1111_1111);
        chk32("t1_c3_addr", imemAddr, 32'h0000_3004);
        gnt = 1'b1; tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h2222_2222; #1;
        chk1("t1_c4_valid", instValid, 1'b0);
        tick();
        rvalid = 1'b0; #1;
        chk32("t1_c5_instpc", instPc, 32'h0000_3004);
        chk32("t1_c5_instr", instr, 32'h2222_2222);
        chk32("t1_c5_addr", imemAddr, 32'h0000_3008);
        gnt = 1'b1; tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h3333_3333; tick();
        rvalid = 1'b0; #1;
        chk32("t1_c7_instpc", instPc, 32'h0000_3008);
        chk32("t1_c7_instr", instr, 32'h3333_3333);
        chk32("t1_c7_addr", imemAddr, 32'h0000_300C);

        // Decode stalled: queue fills to 2, no further issue until a pop
        do_reset();
        chk1("t2_c0_pcadv", pcAdvance, 1'b1);
        tick();
        chk32("t2_c1_addr", imemAddr, 32'h0000_3000);
        gnt = 1'b1; tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'hA0A0_A0A0; #1;
        chk1("t2_c2_pcadv_b2b", pcAdvance, 1'b1);
        tick();
        rvalid = 1'b0; gnt = 1'b1; #1;
        chk32("t2_c3_addr", imemAddr, 32'h0000_3004);
        chk32("t2_c3_instpc", instPc, 32'h0000_3000);
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'hA1A1_A1A1; #1;
        chk1("t2_c4_pcadv_nob2b", pcAdvance, 1'b0);
        tick();
        rvalid = 1'b0; #1;
        chk_state("t2_c5_state", ST_IDLE);
        chk1("t2_c5_req", imemReq, 1'b0);
        chk1("t2_c5_pcadv_full", pcAdvance, 1'b0);
        chk32("t2_c5_head", instPc, 32'h0000_3000);
        tick();
        decodeReady = 1'b1; #1;
        chk1("t2_c6_req", imemReq, 1'b0);
        chk1("t2_c6_pcadv_full", pcAdvance, 1'b0);
        tick();
        decodeReady = 1'b0; #1;
        chk1("t2_c7_valid", instValid, 1'b1);
        chk32("t2_c7_instpc", instPc, 32'h0000_3004);
        chk32("t2_c7_instr", instr, 32'hA1A1_A1A1);
        chk1("t2_c7_pcadv", pcAdvance, 1'b1);
        tick();
        chk1("t2_c8_req", imemReq, 1'b1);
        chk32("t2_c8_addr", imemAddr, 32'h0000_3008);

        // Redirect in WAIT: late word dropped, refetch from target
        gnt = 1'b1; tick();
        gnt = 1'b0; redirect = 1'b1; target = 32'h0000_3100; #1;
        chk_state("t3_c9_state", ST_WAIT);
        chk1("t3_c9_pcadv", pcAdvance, 1'b0);
        tick();
        redirect = 1'b0; #1;
        chk_state("t3_c10_state", ST_DROP);
        chk1("t3_c10_valid", instValid, 1'b0);
        tick();
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; #1;
        chk1("t3_c11_req", imemReq, 1'b0);
        tick();
        rvalid = 1'b0; #1;
        chk_state("t3_c12_state", ST_IDLE);
        chk1("t3_c12_valid", instValid, 1'b0);
        chk1("t3_c12_pcadv", pcAdvance, 1'b1);
        tick();
        chk1("t3_c13_req", imemReq, 1'b1);
        chk32("t3_c13_addr", imemAddr, 32'h0000_3100);

        // Redirect and rvalid together
        gnt = 1'b1; tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        redirect = 1'b1; target = 32'h0000_3200; #1;
        chk1("t4_c14_pcadv", pcAdvance, 1'b0);
        tick();
        rvalid = 1'b0; redirect = 1'b0; #1;
        chk_state("t4_c15_state", ST_IDLE);
        chk1("t4_c15_req", imemReq, 1'b0);
        chk1("t4_c15_valid", instValid, 1'b0);
        chk1("t4_c15_pcadv", pcAdvance, 1'b1);
        tick();
        chk1("t4_c16_req", imemReq, 1'b1);
        chk32("t4_c16_addr", imemAddr, 32'h0000_3200);
        gnt = 1'b1; tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678; tick();
        rvalid = 1'b0; #1;
        chk1("t4_c18_valid", instValid, 1'b1);
        chk32("t4_c18_instpc", instPc, 32'h0000_3200);
        chk32("t4_c18_instr", instr, 32'h1234_5678);
        chk32("t4_c18_addr", imemAddr, 32'h0000_3204);

        // Reset mid-transaction, then misaligned PC
        do_reset();
        chk1("t5_rst_req", imemReq, 1'b0);
        chk32("t5_rst_addr", imemAddr, 32'h0000_3000);
        chk1("t5_rst_valid", instValid, 1'b0);
        redirect = 1'b1; target = 32'h0000_3002;
        rvalid = 1'b1; rdata = 32'hFFFF_FFFF; #1;
        chk1("t5_c0_pcadv_redir", pcAdvance, 1'b0);
        tick();
        redirect = 1'b0; rvalid = 1'b0; #1;
        chk_state("t5_c1_state", ST_IDLE);
        chk1("t5_c1_stale_rvalid", instValid, 1'b0);
        chk1("t5_c1_pcadv_misal", pcAdvance, 1'b0);
        tick();
        chk_state("t5_c2_state", ST_ERR);
        chk1("t5_c2_req", imemReq, 1'b0);
        chk1("t5_c2_valid", instValid, 1'b1);
        chk32("t5_c2_instpc", instPc, 32'h0000_3002);
        chk1("t5_c2_adderr", instAddrErr, 1'b1);
        chk32("t5_c2_instr", instr, 32'h0);
        decodeReady = 1'b1; tick();
        decodeReady = 1'b0; #1;
        chk_state("t5_c3_state", ST_ERR);
        chk1("t5_c3_valid", instValid, 1'b0);
        chk1("t5_c3_pcadv", pcAdvance, 1'b0);
        tick();
        redirect = 1'b1; target = 32'h0000_3010; tick();
        redirect = 1'b0; #1;
        chk_state("t5_c5_state", ST_IDLE);
        chk1("t5_c5_pcadv", pcAdvance, 1'b1);
        chk1("t5_c5_adderr", instAddrErr, 1'b0);
        tick();

        // Grant withheld 5 cycles, redirect in the 2nd
        chk1("t6_c6_req", imemReq, 1'b1);
        chk32("t6_c6_addr", imemAddr, 32'h0000_3010);
        tick();
        redirect = 1'b1; target = 32'h0000_3400; #1;
        chk32("t6_c7_addr", imemAddr, 32'h0000_3010);
        tick();
        redirect = 1'b0; #1;
        chk_state("t6_c8_state", ST_REQ);
        chk32("t6_c8_addr", imemAddr, 32'h0000_3010);
        tick();
        chk32("t6_c9_addr", imemAddr, 32'h0000_3010);
        tick();
        chk32("t6_c10_addr", imemAddr, 32'h0000_3010);
        tick();
        gnt = 1'b1; #1;
        chk1("t6_c11_req", imemReq, 1'b1);
        chk32("t6_c11_addr", imemAddr, 32'h0000_3010);
        tick();
        gnt = 1'b0; #1;
        chk_state("t6_c12_state", ST_DROP);
        chk1("t6_c12_req", imemReq, 1'b0);
`ifdef FETCH_PERF_EN
        chk32("t6_perf_stall", perfBusStall, 32'd5);
        chk32("t6_perf_fetched", perfFetched, 32'd1);
`endif
        redirect = 1'b1; target = 32'h0000_3500; tick();
        redirect = 1'b0; #1;
        chk_state("t6_c13_drop_hold", ST_DROP);
        rvalid = 1'b1; rdata = 32'h0BAD_F00D; tick();
        rvalid = 1'b0; #1;
        chk_state("t6_c14_state", ST_IDLE);
        chk1("t6_c14_valid", instValid, 1'b0);
        chk1("t6_c14_pcadv", pcAdvance, 1'b1);
        tick();
        chk1("t6_c15_req", imemReq, 1'b1);
        chk32("t6_c15_addr", imemAddr, 32'h0000_3500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
